// File: rtl/tile_dma_sequencer_pkg.sv
// Shared controller definitions: sequencer states, DMA transfer types, layer types
// and per-phase transfer counts.
package tile_dma_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_FILTER,
    LD_IFMAP,
    LD_IPSUM,
    LD_BIAS,
    PASS,
    ST_OPSUM,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    IT_FILTER = 3'd0,
    IT_IFMAP  = 3'd1,
    IT_BIAS   = 3'd2,
    IT_OPSUM  = 3'd3,
    IT_IPSUM  = 3'd4,
    IT_OFMAP  = 3'd5
  } input_type_e;

  typedef enum logic [1:0] {
    LT_PW  = 2'd0,
    LT_DW  = 2'd1,
    LT_STD = 2'd2,
    LT_LIN = 2'd3
  } layer_type_e;

  typedef struct packed {
    layer_type_e layer;
    logic [7:0]  d;
    logic [7:0]  k;
    logic        first_d;
    logic        last_d;
  } tile_cfg_t;

  // Number of transfers a phase performs for a tile; 0 means the phase is skipped.
  function automatic logic [7:0] phase_count(state_e s, tile_cfg_t c);
    logic [7:0] out_cnt;
    out_cnt = (c.layer == LT_DW) ? c.d : c.k;
    case (s)
      LD_FILTER: return 8'd1;
      LD_IFMAP:  return (c.d == 8'd0) ? 8'd1 : c.d;
      LD_IPSUM:  return c.first_d ? 8'd0 : out_cnt;
      LD_BIAS:   return c.first_d ? 8'd1 : 8'd0;
      ST_OPSUM:  return out_cnt;
      default:   return 8'd0;
    endcase
  endfunction

  function automatic input_type_e phase_type(state_e s, tile_cfg_t c);
    case (s)
      LD_IFMAP: return IT_IFMAP;
      LD_IPSUM: return IT_IPSUM;
      LD_BIAS:  return IT_BIAS;
      ST_OPSUM: return c.last_d ? IT_OFMAP : IT_OPSUM;
      default:  return IT_FILTER;
    endcase
  endfunction

endpackage

// File: rtl/tile_dma_sequencer_xfer_counter.sv
// Issue/wait handshake and transfer counting for one DMA phase.
module xfer_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] count_i,
  input  logic       dma_done_i,
  output logic       dma_start_o,
  output logic [7:0] idx_o,
  output logic       phase_done_o
);

  logic       start_q;
  logic       wait_q;
  logic [7:0] cnt_q;
  logic [7:0] idx_q;
  logic       last_w;

  assign last_w       = (idx_q == cnt_q - 8'd1);
  assign phase_done_o = wait_q & dma_done_i & last_w;
  assign dma_start_o  = start_q;
  assign idx_o        = idx_q;

  // A done is only honoured while waiting, so issue-cycle and idle pulses fall through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      cnt_q   <= count_i;
      idx_q   <= '0;
      start_q <= 1'b1;
      wait_q  <= 1'b0;
    end else if (start_q) begin
      start_q <= 1'b0;
      wait_q  <= 1'b1;
    end else if (wait_q && dma_done_i) begin
      wait_q <= 1'b0;
      if (last_w) begin
        idx_q <= '0;
      end else begin
        idx_q   <= idx_q + 8'd1;
        start_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_dma_sequencer.sv
// Tile DMA sequencer: loads filter/ifmap/ipsum/bias, launches compute, stores opsum/ofmap.
module tile_dma_sequencer
  import tile_dma_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tile_start_i,
  input  logic [1:0] layer_type_i,
  input  logic [7:0] tile_D_i,
  input  logic [7:0] tile_K_i,
  input  logic       first_d_i,
  input  logic       last_d_i,
  output logic       dma_start_o,
  input  logic       dma_done_i,
  output logic [2:0] input_type_o,
  output logic [7:0] chan_idx_o,
  output logic       pass_start_o,
  input  logic       pass_done_i,
  output logic       busy_o,
  output logic       tile_done_o
);

  state_e     state_q, state_d;
  tile_cfg_t  cfg_q;
  logic [2:0] type_q;
  logic       pass_start_q;
  logic       tile_done_q;
  logic       busy_q;
  logic       load;
  logic [7:0] load_cnt;
  logic       phase_done;

  function automatic state_e next_load_phase(state_e s, tile_cfg_t c);
    case (s)
      LD_FILTER: return LD_IFMAP;
      LD_IFMAP: begin
        if (phase_count(LD_IPSUM, c) != 8'd0) return LD_IPSUM;
        else if (phase_count(LD_BIAS, c) != 8'd0) return LD_BIAS;
        else return PASS;
      end
      LD_IPSUM: return (phase_count(LD_BIAS, c) != 8'd0) ? LD_BIAS : PASS;
      default:  return PASS;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tile_start_i) state_d = LD_FILTER;
      LD_FILTER,
      LD_IFMAP,
      LD_IPSUM,
      LD_BIAS:   if (phase_done) state_d = next_load_phase(state_q, cfg_q);
      PASS: begin
        // The launch cycle itself never counts as completion.
        if (!pass_start_q && pass_done_i)
          state_d = (phase_count(ST_OPSUM, cfg_q) != 8'd0) ? ST_OPSUM : DONE;
      end
      ST_OPSUM:  if (phase_done) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    load_cnt = phase_count(state_d, cfg_q);
    load     = (state_d != state_q) && (load_cnt != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      type_q       <= '0;
      pass_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && tile_start_i) begin
        cfg_q.layer   <= layer_type_e'(layer_type_i);
        cfg_q.d       <= tile_D_i;
        cfg_q.k       <= tile_K_i;
        cfg_q.first_d <= first_d_i;
        cfg_q.last_d  <= last_d_i;
      end
      type_q       <= phase_type(state_d, cfg_q);
      pass_start_q <= (state_d == PASS) && (state_q != PASS);
      tile_done_q  <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
    end
  end

  xfer_counter u_xfer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .count_i      (load_cnt),
    .dma_done_i   (dma_done_i),
    .dma_start_o  (dma_start_o),
    .idx_o        (chan_idx_o),
    .phase_done_o (phase_done)
  );

  assign input_type_o = type_q;
  assign pass_start_o = pass_start_q;
  assign tile_done_o  = tile_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_tile_dma_sequencer.sv
// Bench for tile_dma_sequencer: a per-cycle expected trace is built from the transfer
// rules and fixed DMA/compute latencies, then compared against the DUT every cycle.
module tb_tile_dma_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tile_start_i;
  logic [1:0] layer_type_i;
  logic [7:0] tile_D_i, tile_K_i;
  logic       first_d_i, last_d_i;
  logic       dma_start_o;
  logic       dma_done_i;
  logic [2:0] input_type_o;
  logic [7:0] chan_idx_o;
  logic       pass_start_o;
  logic       pass_done_i;
  logic       busy_o;
  logic       tile_done_o;

  always #5 clk = ~clk;

  tile_dma_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tile_start_i (tile_start_i),
    .layer_type_i (layer_type_i),
    .tile_D_i     (tile_D_i),
    .tile_K_i     (tile_K_i),
    .first_d_i    (first_d_i),
    .last_d_i     (last_d_i),
    .dma_start_o  (dma_start_o),
    .dma_done_i   (dma_done_i),
    .input_type_o (input_type_o),
    .chan_idx_o   (chan_idx_o),
    .pass_start_o (pass_start_o),
    .pass_done_i  (pass_done_i),
    .busy_o       (busy_o),
    .tile_done_o  (tile_done_o)
  );

  // Expected output vector: {busy, tile_done, pass_start, dma_start, type[2:0], idx[7:0]}
  typedef struct {
    logic        start;
    logic        done;
    logic        pdone;
    logic        rstn;
    logic [14:0] exp;
  } cyc_t;

  cyc_t        plan[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  bit          cmp_en   = 1'b0;
  int          done_cyc;
  int          n_starts;
  int          pass_cyc;
  logic [14:0] act;

  task automatic chk(input string nm, input int c, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, c, a, e);
  endtask

  function automatic logic [14:0] pk(bit busy, bit td, bit ps, bit ds, logic [2:0] ty, int idx);
    return {busy, td, ps, ds, ty, 8'(idx)};
  endfunction

  task automatic add(input logic [14:0] e, input bit d, input bit pd);
    cyc_t x;
    x.start = 1'b0; x.done = d; x.pdone = pd; x.rstn = 1'b1; x.exp = e;
    plan.push_back(x);
  endtask

  // One transfer: issue cycle, then L wait cycles, the last carrying dma_done.
  task automatic xfer(input logic [2:0] ty, input int idx, input int L, input bit glitch);
    add(pk(1, 0, 0, 1, ty, idx), glitch, 1'b0);
    for (int k = 1; k <= L; k++) add(pk(1, 0, 0, 0, ty, idx), k == L, 1'b0);
  endtask

  task automatic build(input int lt, input int D, input int K, input bit fd, input bit ld,
                       input int L, input int P, input bit glitch);
    int nif, osz, nip;
    plan.delete();
    add(pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    plan[0].start = 1'b1;
    nif = (D == 0) ? 1 : D;
    osz = (lt == 1) ? D : K;
    nip = fd ? 0 : osz;
    xfer(3'd0, 0, L, glitch);
    for (int i = 0; i < nif; i++) xfer(3'd1, i, L, glitch);
    for (int i = 0; i < nip; i++) xfer(3'd4, i, L, glitch);
    if (fd) xfer(3'd2, 0, L, glitch);
    pass_cyc = plan.size();
    add(pk(1, 0, 1, 0, 0, 0), 1'b0, glitch);
    for (int k = 1; k <= P; k++) add(pk(1, 0, 0, 0, 0, 0), 1'b0, k == P);
    for (int i = 0; i < osz; i++) xfer(ld ? 3'd5 : 3'd3, i, L, glitch);
    add(pk(1, 1, 0, 0, 0, 0), 1'b0, 1'b0);
    add(pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    add(pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
  endtask

  task automatic run(input string nm, input int lt, input int D, input int K, input bit fd,
                     input bit ld, input int L, input int P, input bit glitch, input bit stray,
                     input bit abort, input int exp_pass, input int exp_done, input int exp_starts);
    int a;
    build(lt, D, K, fd, ld, L, P, glitch);
    chk({nm, "_model_pass_cycle"}, 0, pass_cyc, exp_pass);
    if (stray) plan[L + 2].start = 1'b1;
    if (abort) begin
      a = pass_cyc + 1;
      while (plan.size() > a + 1) void'(plan.pop_back());
      plan[a].rstn = 1'b0;
      add(pk(0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      add(pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    end
    layer_type_i = 2'(lt);
    tile_D_i     = 8'(D);
    tile_K_i     = 8'(K);
    first_d_i    = fd;
    last_d_i     = ld;
    done_cyc     = -1;
    n_starts     = 0;
    for (int c = 0; c < plan.size(); c++) begin
      @(posedge clk);
      #1;
      tile_start_i = plan[c].start;
      dma_done_i   = plan[c].done;
      pass_done_i  = plan[c].pdone;
      rst_n        = plan[c].rstn;
      if (c == 1) begin
        // Configuration must have been captured at the start pulse only.
        layer_type_i = 2'd2;
        tile_D_i     = 8'hA5;
        tile_K_i     = 8'h5A;
        first_d_i    = ~fd;
        last_d_i     = ~ld;
      end
      cyc    = c;
      cmp_en = 1'b1;
    end
    @(posedge clk);
    #1;
    cmp_en       = 1'b0;
    tile_start_i = 1'b0;
    dma_done_i   = 1'b0;
    pass_done_i  = 1'b0;
    rst_n        = 1'b1;
    chk({nm, "_tile_done_cycle"}, 0, done_cyc, exp_done);
    chk({nm, "_dma_starts"}, 0, n_starts, exp_starts);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      act = {busy_o, tile_done_o, pass_start_o, dma_start_o, input_type_o, chan_idx_o};
      chk("outputs", cyc, {17'd0, act}, {17'd0, plan[cyc].exp});
      if (tile_done_o) done_cyc = cyc;
      if (dma_start_o) n_starts++;
    end
  end

  initial begin
    rst_n        = 1'b0;
    tile_start_i = 1'b0;
    layer_type_i = '0;
    tile_D_i     = '0;
    tile_K_i     = '0;
    first_d_i    = 1'b0;
    last_d_i     = 1'b0;
    dma_done_i   = 1'b0;
    pass_done_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0,
        {17'd0, busy_o, tile_done_o, pass_start_o, dma_start_o, input_type_o, chan_idx_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    //  name   lt  D  K fd ld  L  P gl st ab  pass done starts
    run("pw_first",   0, 4, 2, 1, 0, 2, 3, 0, 0, 0, 19, 29,  8);
    run("pw_ipsum",   0, 2, 3, 0, 1, 1, 2, 0, 0, 0, 13, 22,  9);
    run("dw_glitch",  1, 8, 5, 0, 0, 1, 2, 1, 0, 0, 35, 54, 25);
    run("zero_dk",    0, 0, 0, 0, 1, 1, 2, 0, 1, 0,  5,  8,  2);
    run("abort_pass", 2, 3, 2, 1, 1, 3, 2, 0, 0, 1, 21, -1,  5);
    run("lin_after",  3, 1, 1, 1, 1, 1, 1, 0, 0, 0,  7, 11,  4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
